// File: rtl/shift_issue_ctrl_pkg.sv
// Shared definitions for the stage-4 shift issue sequencer: op codes, IR layout and FSM states.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'd0;
    localparam logic [1:0] OP_SRL = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    localparam logic [3:0] IR_OPC_BASE = 4'b1000;

    localparam int IR_OPC_MSB = 15;
    localparam int IR_OPC_LSB = 12;
    localparam int IR_IMM_MSB = 11;
    localparam int IR_IMM_LSB = 0;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    // Opcode nibble is the base plus the op; op never exceeds 2 so no carry reaches bit 14.
    function automatic logic [15:0] encode_ir(input logic [1:0] op, input logic [11:0] amt);
        return {IR_OPC_BASE + {2'b00, op}, amt};
    endfunction

endpackage

// File: rtl/shift_issue_ctrl_if.sv
// Request/response handshake bundle between a shift requester (master) and shift_issue_ctrl (slave).
interface shift_issue_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [11:0] req_amt;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [15:0] rsp_ir;

    modport master (
        output req_valid, req_op, req_amt, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_ir
    );

    modport slave (
        input  req_valid, req_op, req_amt, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_ir
    );

endinterface

// File: rtl/shift_issue_ctrl_ref_model.sv
// Combinational expected-result model for an issued IR word; only built with SHIFT_ISSUE_CHECK_EN.
`ifdef SHIFT_ISSUE_CHECK_EN
module shift_ref_model
    import shift_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [15:0] data,
    output logic [15:0] result
);

    logic [3:0]  opc;
    logic [11:0] amt;
    logic        big;

    assign opc = ir[IR_OPC_MSB:IR_OPC_LSB];
    assign amt = ir[IR_IMM_MSB:IR_IMM_LSB];
    assign big = |amt[11:4];

    always_comb begin
        result = 16'h0000;
        if (opc[3:2] == IR_OPC_BASE[3:2]) begin
            case (opc[1:0])
                OP_SLL:  result = big ? 16'h0000 : (data << amt[3:0]);
                OP_SRL:  result = big ? 16'h0000 : (data >> amt[3:0]);
                OP_SRA:  result = big ? {16{data[15]}} : 16'($signed(data) >>> amt[3:0]);
                default: result = 16'h0000;
            endcase
        end
    end

endmodule
`endif

// File: rtl/shift_issue_ctrl.sv
// Stage-4 shift issue sequencer: encodes requests to IR, waits WAIT_CYCLES, captures ShifterOut.
// Optional build macro SHIFT_ISSUE_CHECK_EN adds a sticky reference-model mismatch flag (chk_err).
module shift_issue_ctrl
    import shift_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic               CLK,
    input  logic               CtrlRst,
    shift_issue_ctrl_if.slave  bus,
    output logic [15:0]        IROut,
    output logic [15:0]        ShifterIn,
    input  logic [15:0]        ShifterOut,
    output logic               err_illegal,
    output logic [CNT_W-1:0]   issue_cnt,
    output logic               chk_err
);

    state_t             state_q, state_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [15:0]        ir_q, ir_d;
    logic [15:0]        shin_q, shin_d;
    logic [15:0]        rsp_data_q, rsp_data_d;
    logic [15:0]        rsp_ir_q, rsp_ir_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               chk_q, chk_d;
    logic               capture;

`ifdef SHIFT_ISSUE_CHECK_EN
    logic [15:0] model_result;

    shift_ref_model u_ref_model (
        .ir     (ir_q),
        .data   (shin_q),
        .result (model_result)
    );
`endif

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ir_d       = ir_q;
        shin_d     = shin_q;
        rsp_data_d = rsp_data_q;
        rsp_ir_d   = rsp_ir_q;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        capture    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_op == OP_ILL) begin
                        err_d = 1'b1;
                    end else begin
                        ir_d    = encode_ir(bus.req_op, bus.req_amt);
                        shin_d  = bus.req_data;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (WAIT_CYCLES == 0) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = 4'(WAIT_CYCLES);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            default: begin
                if (bus.rsp_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (capture) begin
            rsp_data_d = ShifterOut;
            rsp_ir_d   = ir_q;
        end

`ifdef SHIFT_ISSUE_CHECK_EN
        chk_d = chk_q | (capture & (model_result != ShifterOut));
`else
        chk_d = 1'b0;
`endif
    end

    always_ff @(posedge CLK or negedge CtrlRst) begin
        if (!CtrlRst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            ir_q       <= 16'h0000;
            shin_q     <= 16'h0000;
            rsp_data_q <= 16'h0000;
            rsp_ir_q   <= 16'h0000;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            chk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ir_q       <= ir_d;
            shin_q     <= shin_d;
            rsp_data_q <= rsp_data_d;
            rsp_ir_q   <= rsp_ir_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            chk_q      <= chk_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_ir    = rsp_ir_q;
    assign IROut         = ir_q;
    assign ShifterIn     = shin_q;
    assign err_illegal   = err_q;
    assign issue_cnt     = cnt_q;
    assign chk_err       = chk_q;

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Bench for shift_issue_ctrl: fixed vector table, corner sequences and random ops against a shift model.
module tb_shift_issue_ctrl;

    localparam int W = 1;

    logic        CLK = 1'b0;
    logic        CtrlRst;
    logic [15:0] IROut;
    logic [15:0] ShifterIn;
    logic [15:0] ShifterOut;
    logic        err_illegal;
    logic [15:0] issue_cnt;
    logic        chk_err;
    logic        corrupt = 1'b0;

    int total = 0;
    int bad = 0;
    int model_cnt = 0;
    logic [15:0] last_ir = 16'h0000;
    logic [15:0] last_data = 16'h0000;

    shift_issue_ctrl_if bus_if ();

    shift_issue_ctrl #(.WAIT_CYCLES(W), .CNT_W(16)) dut (
        .CLK         (CLK),
        .CtrlRst     (CtrlRst),
        .bus         (bus_if),
        .IROut       (IROut),
        .ShifterIn   (ShifterIn),
        .ShifterOut  (ShifterOut),
        .err_illegal (err_illegal),
        .issue_cnt   (issue_cnt),
        .chk_err     (chk_err)
    );

    always #5 CLK = ~CLK;

    // Arithmetic shift reference: op 0=SLL, 1=SRL, 2=SRA.
    function automatic logic [15:0] ref_shift(input int op, input int amt, input logic [15:0] data);
        longint v;
        int     s;
        case (op)
            0: begin
                if (amt >= 16) return 16'h0000;
                v = longint'(data) * (longint'(1) << amt);
                return 16'(v);
            end
            1: begin
                if (amt >= 16) return 16'h0000;
                return 16'(int'(data) / (1 << amt));
            end
            2: begin
                if (amt >= 16) return data[15] ? 16'hFFFF : 16'h0000;
                s = data[15] ? int'(data) - 65536 : int'(data);
                return 16'(s >>> amt);
            end
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] stage4(input logic [15:0] ir, input logic [15:0] data);
        int op;
        op = int'(ir[15:12]) - 8;
        if (op < 0 || op > 2) return 16'h0000;
        return ref_shift(op, int'(ir[11:0]), data);
    endfunction

    function automatic logic [15:0] exp_ir_of(input int op, input int amt);
        return 16'(((8 + op) * 4096) + amt);
    endfunction

    assign ShifterOut = stage4(IROut, ShifterIn) ^ {15'd0, corrupt};

    typedef struct {
        logic [1:0]  op;
        logic [11:0] amt;
        logic [15:0] data;
        logic [15:0] exp_ir;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] op, input logic [11:0] amt, input logic [15:0] data);
        int n = 0;
        while (!bus_if.req_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check_output("req_ready_before_issue", 32'(bus_if.req_ready), 32'd1);
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = op;
        bus_if.req_amt   = amt;
        bus_if.req_data  = data;
        @(negedge CLK);
        bus_if.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus_if.rsp_valid && n < 40) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [11:0] amt, input logic [15:0] data,
                          input logic [15:0] exp_ir, input logic [15:0] exp_data, input int hold);
        int n;
        apply_stimulus(op, amt, data);
        check_output("iro_after_accept", 32'(IROut), 32'(exp_ir));
        check_output("shin_after_accept", 32'(ShifterIn), 32'(data));
        check_output("req_ready_busy", 32'(bus_if.req_ready), 32'd0);
        last_ir   = exp_ir;
        last_data = data;
        wait_rsp(n);
        check_output("rsp_latency", 32'(n), 32'(W + 1));
        check_output("rsp_data", 32'(bus_if.rsp_data), 32'(exp_data));
        check_output("rsp_ir", 32'(bus_if.rsp_ir), 32'(exp_ir));
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            check_output("rsp_valid_hold", 32'(bus_if.rsp_valid), 32'd1);
            check_output("rsp_data_hold", 32'(bus_if.rsp_data), 32'(exp_data));
        end
        bus_if.rsp_ready = 1'b1;
        @(negedge CLK);
        bus_if.rsp_ready = 1'b0;
        model_cnt++;
        check_output("rsp_valid_after_hs", 32'(bus_if.rsp_valid), 32'd0);
        check_output("issue_cnt", 32'(issue_cnt), 32'(model_cnt & 16'hFFFF));
`ifndef SHIFT_ISSUE_CHECK_EN
        check_output("chk_err_off", 32'(chk_err), 32'd0);
`endif
    endtask

    task automatic run_illegal(input logic [11:0] amt, input logic [15:0] data);
        apply_stimulus(2'd3, amt, data);
        check_output("err_illegal_pulse", 32'(err_illegal), 32'd1);
        check_output("iro_unchanged_ill", 32'(IROut), 32'(last_ir));
        check_output("shin_unchanged_ill", 32'(ShifterIn), 32'(last_data));
        check_output("req_ready_ill", 32'(bus_if.req_ready), 32'd1);
        @(negedge CLK);
        check_output("err_illegal_clear", 32'(err_illegal), 32'd0);
        check_output("rsp_valid_ill", 32'(bus_if.rsp_valid), 32'd0);
        check_output("issue_cnt_ill", 32'(issue_cnt), 32'(model_cnt & 16'hFFFF));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [1:0]  rop;
        logic [11:0] ramt;
        logic [15:0] rdata;

        vecs[0] = '{2'd0, 12'd4,  16'hFFFE, 16'h8004, 16'hFFE0};
        vecs[1] = '{2'd2, 12'd3,  16'h8000, 16'hA003, 16'hF000};
        vecs[2] = '{2'd1, 12'd3,  16'h8000, 16'h9003, 16'h1000};
        vecs[3] = '{2'd0, 12'd16, 16'h1234, 16'h8010, 16'h0000};
        vecs[4] = '{2'd2, 12'd20, 16'h8001, 16'hA014, 16'hFFFF};
        vecs[5] = '{2'd1, 12'd0,  16'hABCD, 16'h9000, 16'hABCD};
        vecs[6] = '{2'd2, 12'd15, 16'h7FFF, 16'hA00F, 16'h0000};
        vecs[7] = '{2'd0, 12'd15, 16'h0001, 16'h800F, 16'h8000};

        CtrlRst          = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_op    = 2'd0;
        bus_if.req_amt   = 12'd0;
        bus_if.req_data  = 16'h0000;
        bus_if.rsp_ready = 1'b0;
        #12;
        check_output("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
        check_output("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check_output("rst_iro", 32'(IROut), 32'd0);
        check_output("rst_issue_cnt", 32'(issue_cnt), 32'd0);
        check_output("rst_err", 32'(err_illegal), 32'd0);
        check_output("rst_chk", 32'(chk_err), 32'd0);
        @(negedge CLK);
        CtrlRst = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].op, vecs[i].amt, vecs[i].data, vecs[i].exp_ir, vecs[i].exp_data, i % 3);

        run_illegal(12'd5, 16'h5555);

        // Long response stall with a competing request that must be ignored.
        apply_stimulus(2'd1, 12'd4, 16'hF0F0);
        last_ir   = 16'h9004;
        last_data = 16'hF0F0;
        wait_rsp(n);
        check_output("stall_latency", 32'(n), 32'(W + 1));
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = 2'd0;
        bus_if.req_amt   = 12'd1;
        bus_if.req_data  = 16'h0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check_output("stall_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
            check_output("stall_rsp_data", 32'(bus_if.rsp_data), 32'h0F0F);
            check_output("stall_req_ready", 32'(bus_if.req_ready), 32'd0);
        end
        bus_if.req_valid = 1'b0;
        bus_if.rsp_ready = 1'b1;
        @(negedge CLK);
        bus_if.rsp_ready = 1'b0;
        model_cnt++;
        check_output("stall_issue_cnt", 32'(issue_cnt), 32'(model_cnt));
        check_output("stall_rsp_valid_off", 32'(bus_if.rsp_valid), 32'd0);
        @(negedge CLK);
        check_output("stall_iro_kept", 32'(IROut), 32'h9004);
        check_output("stall_no_new_rsp", 32'(bus_if.rsp_valid), 32'd0);

        // Asynchronous reset while the request sits in the wait state.
        apply_stimulus(2'd0, 12'd2, 16'h00F0);
        @(negedge CLK);
        #2 CtrlRst = 1'b0;
        #1;
        check_output("midrst_iro", 32'(IROut), 32'd0);
        check_output("midrst_shin", 32'(ShifterIn), 32'd0);
        check_output("midrst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check_output("midrst_req_ready", 32'(bus_if.req_ready), 32'd1);
        check_output("midrst_issue_cnt", 32'(issue_cnt), 32'd0);
        check_output("midrst_rsp_data", 32'(bus_if.rsp_data), 32'd0);
        model_cnt = 0;
        last_ir   = 16'h0000;
        last_data = 16'h0000;
        @(negedge CLK);
        CtrlRst = 1'b1;
        @(negedge CLK);
        check_output("postrst_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
        run_op(2'd0, 12'd2, 16'h00F0, 16'h8002, 16'h03C0, 1);

        for (int i = 0; i < 30; i++) begin
            rop   = 2'($urandom_range(0, 3));
            ramt  = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 17));
            rdata = 16'($urandom);
            if (rop == 2'd3)
                run_illegal(ramt, rdata);
            else
                run_op(rop, ramt, rdata, exp_ir_of(int'(rop), int'(ramt)),
                       ref_shift(int'(rop), int'(ramt), rdata), int'($urandom_range(0, 2)));
        end

`ifdef SHIFT_ISSUE_CHECK_EN
        corrupt = 1'b1;
        run_op(2'd0, 12'd1, 16'h0003, 16'h8001, 16'h0007, 0);
        check_output("chk_err_set", 32'(chk_err), 32'd1);
        corrupt = 1'b0;
        run_op(2'd1, 12'd1, 16'h0004, 16'h9001, 16'h0002, 0);
        check_output("chk_err_sticky", 32'(chk_err), 32'd1);
`else
        check_output("chk_err_final", 32'(chk_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_issue_ctrl.md
Name: shift_issue_ctrl

Overview:
- Initiator-side sequencer for the stage-4 shift datapath. Stage 4 decodes an IR word and shifts ShifterIn; this block does the reverse.
- It accepts a shift request (op, amount, operand) on a valid/ready port and encodes it into the 16-bit IR shift format.
- It drives IROut and ShifterIn into stage 4, waits a fixed settle time, captures ShifterOut and returns the result on a valid/ready response port.
- Used as a standalone shift service and as the stimulus front end for stage-4 bring-up.

Parameters:
- WAIT_CYCLES, 1, cycles between issue and ShifterOut capture (0..15 legal).
- CNT_W, 16, width of the issued-operation counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- CtrlRst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  0=SLL, 1=SRL, 2=SRA, 3=illegal.
- req_amt  in  12  shift amount (IR immediate field).
- req_data  in  16  operand.
- IROut  out  16  encoded IR word to stage 4.
- ShifterIn  out  16  operand to stage 4.
- ShifterOut  in  16  stage-4 shifter result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  16  captured ShifterOut.
- rsp_ir  out  16  IR word that produced rsp_data.
- err_illegal  out  1  one-cycle pulse when an illegal op is accepted.
- issue_cnt  out  CNT_W  count of completed (handshaken) responses; wraps modulo 2^CNT_W.
- chk_err  out  1  sticky model mismatch (see Optional Feature).

Behaviour:
- Reset (CtrlRst=0, async): state IDLE. All outputs 0 except req_ready=1. Wait counter 0.
- Reset mid-operation: abandons the in-flight request; rsp_valid falls immediately; no response is ever produced for it.
- IR encoding: IROut = {4'b1000 + req_op, req_amt}.
  - SLL=8xxx, SRL=9xxx, SRA=Axxx.
- IDLE, req_ready=1. On req_valid & req_ready:
  - op==3: err_illegal=1 next cycle, stay IDLE, IROut/ShifterIn unchanged, issue_cnt unchanged.
  - otherwise: latch op/amt/data, register IROut/ShifterIn (visible next cycle), go ISSUE.
- ISSUE (1 cycle), req_ready=0, outputs held.
  - WAIT_CYCLES==0: capture ShifterOut into rsp_data and IROut into rsp_ir at the end of this cycle, go RESP.
  - else: load the wait counter with WAIT_CYCLES, go WAIT.
- WAIT: decrement each cycle. On the cycle the counter reads 1, capture ShifterOut and IROut, go RESP.
  - Capture is therefore WAIT_CYCLES+1 edges after the accept edge.
- RESP: rsp_valid=1; rsp_data and rsp_ir stable until handshake.
  - On rsp_ready: rsp_valid=0, issue_cnt+1, go IDLE.
- IROut/ShifterIn hold their last issued values in IDLE; they change only on a new accept.
- Back-to-back: req_ready is 0 in RESP, so no request is accepted in the same cycle as a response handshake. Minimum spacing is WAIT_CYCLES+3 cycles per operation.
- req_* changes while req_ready=0 are ignored. rsp_ready while rsp_valid=0 is ignored.
- Amount ≥16 is passed through unchanged; the result is whatever stage 4 produces.

Optional Feature:
- Macro SHIFT_ISSUE_CHECK_EN.
- When defined, an internal reference model computes the expected result at capture time:
  - SLL: data << amt (0 if amt ≥ 16).
  - SRL: data >> amt (0 if amt ≥ 16).
  - SRA: $signed(data) >>> amt (sign-fill if amt ≥ 16).
- If the model differs from ShifterOut, chk_err goes to 1 and stays set until reset.
- When undefined: no model logic, chk_err tied 0.

Decomposition:
- Shared package shift_pkg holds:
  - op encodings (OP_SLL=0, OP_SRL=1, OP_SRA=2).
  - IR opcode base 4'b1000.
  - IR field slices (opcode [15:12], immediate [11:0]).
  - state enum IDLE/ISSUE/WAIT/RESP.
- One sub-module: shift_ref_model, a combinational expected-result function, instantiated only under SHIFT_ISSUE_CHECK_EN.

Test Plan:
- Reset then SLL, amt=4, data=FFFE, WAIT_CYCLES=1, stage-4 model attached -> IROut=8004, capture 2 edges after accept, rsp_data=FFE0, rsp_ir=8004, issue_cnt=1.
- SRA, amt=3, data=8000 -> IROut=A003, rsp_data=F000. SRL, same amt/data -> IROut=9003, rsp_data=1000.
- req_op=3, amt=5 -> err_illegal pulses one cycle, IROut unchanged, no rsp_valid, issue_cnt unchanged.
- Hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=0, new req_valid ignored. Raise rsp_ready -> single handshake, issue_cnt+1.
- Assert CtrlRst low during WAIT -> outputs zero asynchronously, req_ready=1. After release, the next request completes normally.
- SHIFT_ISSUE_CHECK_EN, stage-4 stub returning data XOR 1 -> chk_err=1 after the first capture and stays set. Without the macro, chk_err=0 throughout.
